// File: rtl/demux1ton_stream.sv
// 1-to-N streaming demultiplexer: one holding register plus valid flag per channel.
// Optional saturating drop counter for out-of-range selects, enabled by DEMUX_DROPCNT_EN.
module demux1ton_stream #(
  parameter int WIDTH = 4,
  parameter int N     = 2,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     X,
  input  logic [SELW-1:0]      C,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [N*WIDTH-1:0]   Y,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready
`ifdef DEMUX_DROPCNT_EN
  ,
  output logic [7:0]           DROP_CNT
`endif
);

  // Handshake: a word moves when valid && ready at a rising edge. in_ready never
  // looks at in_valid; once out_valid[k] rises it stays up until out_ready[k] takes it.
  logic [N*WIDTH-1:0] r_y;
  logic [N-1:0]       r_valid;
  logic [N-1:0]       w_sel;
  logic [N-1:0]       w_ch_ready;
  logic [N-1:0]       w_load;
  logic [N-1:0]       w_consume;
  logic               w_in_range;
  logic               w_xfer;

  always_comb begin
    w_sel      = '0;
    w_ch_ready = '0;
    for (int k = 0; k < N; k++) begin
      w_sel[k]      = (32'(C) == 32'(k));
      w_ch_ready[k] = !r_valid[k] || out_ready[k];
    end
  end

  // Out-of-range selects are always accepted so they can be discarded.
  assign w_in_range = (32'(C) < 32'(N));
  assign in_ready   = w_in_range ? |(w_sel & w_ch_ready) : 1'b1;
  assign w_xfer     = in_valid && in_ready;
  assign w_load     = (w_xfer && w_in_range) ? w_sel : '0;
  assign w_consume  = r_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_y     <= '0;
      r_valid <= '0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (w_load[k]) begin
          r_y[k*WIDTH +: WIDTH] <= X;
          r_valid[k]            <= 1'b1;
        end else if (w_consume[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign Y         = r_y;
  assign out_valid = r_valid;

`ifdef DEMUX_DROPCNT_EN
  logic [7:0] r_drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_xfer && !w_in_range && (r_drop != 8'hFF)) begin
      r_drop <= r_drop + 8'd1;
    end
  end

  assign DROP_CNT = r_drop;
`endif

endmodule

// File: tb/tb_demux1ton_stream.sv
// Bench for demux1ton_stream (N=4, WIDTH=4, SELW=3 so selects 4..7 are out of range).
// Directed cases plus a random phase checked against a per-channel scoreboard.
module tb_demux1ton_stream;

  localparam int WIDTH = 4;
  localparam int N     = 4;
  localparam int SELW  = 3;

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   X;
  logic [SELW-1:0]    C;
  logic               in_valid;
  logic               in_ready;
  logic [N*WIDTH-1:0] Y;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;
`ifdef DEMUX_DROPCNT_EN
  logic [7:0]         DROP_CNT;
`endif

  demux1ton_stream #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .X         (X),
    .C         (C),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Y         (Y),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef DEMUX_DROPCNT_EN
    ,
    .DROP_CNT  (DROP_CNT)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_drop = 0;
  logic [5:0] exp_q[$];  // {channel[1:0], data[3:0]}

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [SELW-1:0] c, input logic [WIDTH-1:0] x);
    in_valid = v;
    C        = c;
    X        = x;
  endtask

  // Scoreboard: samples at negedge what the coming posedge will do.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      exp_drop = 0;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (out_valid[k] && out_ready[k]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i][5:4] == 2'(k)) idx = i;
          end
          if (idx < 0) begin
            check_eq($sformatf("sb_extra_word_ch%0d", k), 32'(Y[k*WIDTH +: WIDTH]), 32'hFFFF_FFFF);
          end else begin
            check_eq($sformatf("sb_data_ch%0d", k), 32'(Y[k*WIDTH +: WIDTH]), 32'(exp_q[idx][3:0]));
            exp_q.delete(idx);
          end
        end
      end
      if (in_valid && in_ready) begin
        if (C < SELW'(N)) exp_q.push_back({C[1:0], X});
        else if (exp_drop < 255) exp_drop++;
      end
    end
  end

  logic bad_ready;
  logic bad_valid;

  initial begin
    rst = 1'b1;
    out_ready = '1;
    drive(1'b0, '0, '0);
    step(); step();
    check_eq("reset_out_valid", 32'(out_valid), 32'h0);
    check_eq("reset_y", 32'(Y), 32'h0);
    rst = 1'b0;
    #1;
    check_eq("idle_in_ready", 32'(in_ready), 32'h1);

    // Single word, latency one, cleared next cycle
    drive(1'b1, 3'd2, 4'hA);
    step();
    drive(1'b0, '0, '0);
    check_eq("single_out_valid", 32'(out_valid), 32'b0100);
    check_eq("single_y", 32'(Y[11:8]), 32'hA);
    step();
    check_eq("single_cleared", 32'(out_valid), 32'h0);

    // Back-pressure on channel 1
    out_ready = 4'b1101;
    drive(1'b1, 3'd1, 4'h3);
    #1 check_eq("bp_first_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b1, 3'd1, 4'h5);
    #1 check_eq("bp_second_blocked", 32'(in_ready), 32'h0);
    step();
    check_eq("bp_still_blocked", 32'(in_ready), 32'h0);
    check_eq("bp_held_data", 32'(Y[7:4]), 32'h3);
    out_ready = 4'b1111;
    #1 check_eq("bp_released_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, '0, '0);
    check_eq("bp_second_data", 32'(Y[7:4]), 32'h5);
    check_eq("bp_second_valid", 32'(out_valid[1]), 32'h1);
    step();
    check_eq("bp_drained", 32'(out_valid), 32'h0);

    // Channel independence: channel 1 stalled, channel 0 flows
    out_ready = 4'b1101;
    drive(1'b1, 3'd1, 4'h6);
    step();
    drive(1'b1, 3'd0, 4'h7);
    #1 check_eq("indep_ready", 32'(in_ready), 32'h1);
    step();
    drive(1'b0, '0, '0);
    check_eq("indep_ch0_data", 32'(Y[3:0]), 32'h7);
    check_eq("indep_valid", 32'(out_valid), 32'b0011);
    out_ready = 4'b1111;
    step(); step();

    // Back-to-back on channel 3
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 3'd3, 4'(i));
      #1 check_eq($sformatf("b2b_ready_%0d", i), 32'(in_ready), 32'h1);
      step();
      check_eq($sformatf("b2b_data_%0d", i), 32'(Y[15:12]), 32'(i));
    end
    drive(1'b0, '0, '0);
    step();
    check_eq("b2b_drained", 32'(out_valid), 32'h0);

    // Out-of-range selects: 300 drops, boundary C == N first
    bad_ready = 1'b0;
    bad_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, (i == 0) ? 3'd4 : 3'($urandom_range(4, 7)), 4'($urandom_range(0, 15)));
      #1 if (!in_ready) bad_ready = 1'b1;
      step();
      if (out_valid != '0) bad_valid = 1'b1;
    end
    drive(1'b0, '0, '0);
    check_eq("drop_in_ready_high", 32'(bad_ready), 32'h0);
    check_eq("drop_no_valid", 32'(bad_valid), 32'h0);
`ifdef DEMUX_DROPCNT_EN
    check_eq("drop_cnt_sat", 32'(DROP_CNT), 32'd255);
`endif

    // Reset mid-stream with a word presented in the reset cycle
    out_ready = 4'b0000;
    drive(1'b1, 3'd0, 4'h9);
    step();
    drive(1'b1, 3'd2, 4'hC);
    step();
    check_eq("pre_rst_valid", 32'(out_valid), 32'b0101);
    rst = 1'b1;
    drive(1'b1, 3'd1, 4'hE);
    step();
    rst = 1'b0;
    drive(1'b0, '0, '0);
    check_eq("rst_flush_valid", 32'(out_valid), 32'h0);
    check_eq("rst_flush_y", 32'(Y), 32'h0);
`ifdef DEMUX_DROPCNT_EN
    check_eq("rst_drop_cnt", 32'(DROP_CNT), 32'h0);
`endif
    step();
    check_eq("rst_no_load", 32'(out_valid), 32'h0);

    // Random traffic with random sinks, checked by the scoreboard
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 4'($urandom_range(0, 15)));
      out_ready = 4'($urandom_range(0, 15));
      step();
    end
    drive(1'b0, '0, '0);
    out_ready = '1;
    for (int i = 0; i < 4; i++) step();
    check_eq("final_drained", 32'(out_valid), 32'h0);
    check_eq("final_sb_empty", 32'(exp_q.size()), 32'h0);
`ifdef DEMUX_DROPCNT_EN
    check_eq("final_drop_cnt", 32'(DROP_CNT), 32'(exp_drop));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/demux1ton_stream.md
DEMUX1TON_STREAM -- requirements
Module: demux1ton_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the data width in bits (minimum 1).
REQ-002 The block SHALL have parameter N, default 2, giving the output channel count (minimum 2).
REQ-003 The block SHALL have parameter SELW, default $clog2(N), giving the select width.
REQ-004 The block SHALL have port clk  input  1  system clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-006 The block SHALL have port X  input  WIDTH  input data word.
REQ-007 The block SHALL have port C  input  SELW  channel select for X.
REQ-008 The block SHALL have port in_valid  input  1  X/C hold a word to transfer.
REQ-009 The block SHALL have port in_ready  output  1  block accepts the word this cycle.
REQ-010 The block SHALL have port Y  output  N*WIDTH  channel k data in bits [k*WIDTH +: WIDTH].
REQ-011 The block SHALL have port out_valid  output  N  bit k set means channel k holds an unconsumed word.
REQ-012 The block SHALL have port out_ready  input  N  bit k set means the channel k sink takes its word.

Function
REQ-013 Each channel SHALL contain exactly one WIDTH-bit holding register plus a valid flag; no other data storage exists.
REQ-014 A transfer SHALL occur in any cycle where in_valid and in_ready are both 1.
REQ-015 For C < N, in_ready SHALL be combinationally (!out_valid[C] || out_ready[C]).
REQ-016 For C >= N (out of range), in_ready SHALL be 1; the word is accepted and discarded with no channel updated.
REQ-017 On a transfer with C = k < N, channel k register SHALL load X and out_valid[k] SHALL be 1 on the next cycle (latency 1 clock).
REQ-018 On a consume (out_valid[k] and out_ready[k]) with no simultaneous load of channel k, out_valid[k] SHALL clear on the next cycle.
REQ-019 Consume and load of the same channel in one cycle SHALL leave out_valid[k] = 1 with the new word, giving one word per clock throughput.
REQ-020 When out_valid[k] is 0 or out_ready[k] is 0, channel k data SHALL hold its previous value; Y bits SHALL never change except on a load.
REQ-021 Channels SHALL be independent: back-pressure on channel k SHALL NOT affect in_ready for C selecting any other channel.
REQ-022 The block SHALL NOT lose, duplicate or reorder words within a channel.
REQ-023 in_ready SHALL NOT depend on in_valid.

Reset
REQ-024 While rst = 1 at a clock edge, all out_valid bits SHALL be 0, all Y bits SHALL be 0, and DROP_CNT (when present) SHALL be 0.
REQ-025 Reset SHALL take priority over any simultaneous transfer or consume; a word presented in the reset cycle SHALL be discarded.
REQ-026 Reset asserted mid-stream SHALL flush all held words with no partial state retained.

Configuration
REQ-027 With macro DEMUX_DROPCNT_EN defined, the block SHALL add port DROP_CNT  output  8  count of words accepted with C >= N.
REQ-028 DROP_CNT SHALL increment by 1 per out-of-range transfer and saturate at 255.
REQ-029 Without DEMUX_DROPCNT_EN, the DROP_CNT port and counter SHALL be absent, and out-of-range words SHALL be silently discarded.

Verification
REQ-030 With N=4, WIDTH=4, and all out_ready=1: X=4'hA, C=2 for 1 cycle -> next cycle out_valid=4'b0100 with Y[11:8]=4'hA, then out_valid=0 one cycle later.
REQ-031 With out_ready[1]=0: send 4'h3 to C=1, then 4'h5 to C=1 -> in_ready=0 on the second word until out_ready[1]=1; Y[7:4]=3 is consumed first, then 5.
REQ-032 With channel 1 stalled (out_valid[1]=1, out_ready[1]=0): send 4'h7 to C=0 -> in_ready=1 and channel 0 receives 7 in 1 cycle.
REQ-033 With all out_ready=1: back-to-back words 1,2,3,4 to C=3 -> one word per clock on channel 3, in order, with no in_ready deassertion.
REQ-034 With N=3 and DEMUX_DROPCNT_EN defined: 300 transfers with C=3 -> in_ready stays 1, no out_valid bit rises, DROP_CNT=255.
REQ-035 With channels 0 and 2 holding words: pulse rst for 1 cycle together with in_valid=1 -> out_valid=0, Y=0, and no word loaded.
